// File: rtl/tl_error_slave.sv
// TileLink-UH error slave: swallows A-channel messages to unmapped space
// and answers each with denied D-channel responses, in request order.
module tl_error_slave #(
    parameter int BEAT_BYTES  = 8,
    parameter int SOURCE_BITS = 5,
    parameter int SIZE_BITS   = 4,
    parameter int QUEUE_DEPTH = 2,
    parameter int COUNT_BITS  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    a_ready,
    input  logic                    a_valid,
    input  logic [2:0]              a_bits_opcode,
    input  logic [SIZE_BITS-1:0]    a_bits_size,
    input  logic [SOURCE_BITS-1:0]  a_bits_source,
    input  logic                    d_ready,
    output logic                    d_valid,
    output logic [2:0]              d_bits_opcode,
    output logic [1:0]              d_bits_param,
    output logic [SIZE_BITS-1:0]    d_bits_size,
    output logic [SOURCE_BITS-1:0]  d_bits_source,
    output logic                    d_bits_sink,
    output logic                    d_bits_denied,
    output logic [8*BEAT_BYTES-1:0] d_bits_data,
    output logic                    d_bits_corrupt,
    input  logic                    err_clear,
    output logic [COUNT_BITS-1:0]   err_count
);

    localparam int LB = $clog2(BEAT_BYTES);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int HW = 3 + SIZE_BITS + SOURCE_BITS;

    // Index of the final beat of a message of the given size (beats - 1).
    function automatic logic [SIZE_BITS-1:0] f_last_beat(
        input logic [SIZE_BITS-1:0] size
    );
        int sh;
        sh = int'(size) - LB;
        if (sh <= 0) return '0;
        return SIZE_BITS'((32'd1 << sh) - 32'd1);
    endfunction

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                   r_a_busy;
    logic [SIZE_BITS-1:0]   r_a_left;
    logic [HW-1:0]          r_a_hdr;
    logic [HW-1:0]          r_q [QUEUE_DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_cnt;
    logic [SIZE_BITS-1:0]   r_d_beat;
    logic [COUNT_BITS-1:0]  r_err;

    logic                   w_a_first_last;
    logic                   w_a_last;
    logic                   w_full;
    logic                   w_a_hs;
    logic                   w_enq;
    logic [HW-1:0]          w_hdr_in;
    logic [HW-1:0]          w_enq_hdr;
    logic [HW-1:0]          w_head;
    logic [2:0]             w_h_op;
    logic [SIZE_BITS-1:0]   w_h_size;
    logic [SOURCE_BITS-1:0] w_h_src;
    logic [2:0]             w_d_op;
    logic                   w_h_data;
    logic                   w_d_last;
    logic                   w_d_hs;
    logic                   w_pop;

    assign w_hdr_in = {a_bits_opcode, a_bits_size, a_bits_source};
    assign w_a_first_last = !(!a_bits_opcode[2] &&
                              (f_last_beat(a_bits_size) != '0));
    assign w_a_last = r_a_busy ? (r_a_left == SIZE_BITS'(1))
                               : w_a_first_last;
    assign w_full = (r_cnt == CW'(QUEUE_DEPTH));

    // Only the beat that completes a message needs a free queue slot.
    assign a_ready   = !reset && (!w_a_last || !w_full);
    assign w_a_hs    = a_valid && a_ready;
    assign w_enq     = w_a_hs && w_a_last;
    assign w_enq_hdr = r_a_busy ? r_a_hdr : w_hdr_in;

    assign w_head   = r_q[r_rptr];
    assign w_h_op   = w_head[HW-1 -: 3];
    assign w_h_size = w_head[SOURCE_BITS +: SIZE_BITS];
    assign w_h_src  = w_head[SOURCE_BITS-1:0];

    always_comb begin
        w_d_op   = 3'd0;
        w_h_data = 1'b0;
        case (w_h_op)
            3'd2, 3'd3, 3'd4: begin
                w_d_op   = 3'd1;
                w_h_data = 1'b1;
            end
            3'd5:    w_d_op = 3'd2;
            default: w_d_op = 3'd0;
        endcase
    end

    assign w_d_last = !w_h_data || (r_d_beat == f_last_beat(w_h_size));
    assign d_valid  = (r_cnt != '0);
    assign w_d_hs   = d_valid && d_ready;
    assign w_pop    = w_d_hs && w_d_last;

    assign d_bits_opcode  = w_d_op;
    assign d_bits_param   = 2'd0;
    assign d_bits_size    = w_h_size;
    assign d_bits_source  = w_h_src;
    assign d_bits_sink    = 1'b0;
    assign d_bits_denied  = 1'b1;
    assign d_bits_data    = '0;
    assign d_bits_corrupt = w_h_data;
    assign err_count      = r_err;

    always_ff @(posedge clock) begin
        if (w_enq) r_q[r_wptr] <= w_enq_hdr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a_busy <= 1'b0;
            r_a_left <= '0;
            r_a_hdr  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_d_beat <= '0;
            r_err    <= '0;
        end else begin
            if (w_a_hs) begin
                if (!r_a_busy) begin
                    if (!w_a_first_last) begin
                        r_a_busy <= 1'b1;
                        r_a_left <= f_last_beat(a_bits_size);
                        r_a_hdr  <= w_hdr_in;
                    end
                end else begin
                    r_a_left <= r_a_left - 1'b1;
                    if (w_a_last) r_a_busy <= 1'b0;
                end
            end
            if (w_enq) r_wptr <= f_next(r_wptr);
            if (w_pop) r_rptr <= f_next(r_rptr);
            if (w_enq && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_enq && w_pop) r_cnt <= r_cnt - 1'b1;
            if (w_d_hs) r_d_beat <= w_d_last ? '0 : r_d_beat + 1'b1;
            if (err_clear)                 r_err <= '0;
            else if (w_pop && r_err != '1) r_err <= r_err + 1'b1;
        end
    end

endmodule

// File: tb/tb_tl_error_slave.sv
// Bench for tl_error_slave: directed scenarios then random traffic,
// checked against a message-level response queue model.
module tb_tl_error_slave;

    localparam int BB  = 8;
    localparam int SRB = 5;
    localparam int SZB = 4;
    localparam int QD  = 2;
    localparam int CB  = 2;
    localparam int CMAX = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           a_ready;
    logic           a_valid = 1'b0;
    logic [2:0]     a_bits_opcode = '0;
    logic [SZB-1:0] a_bits_size = '0;
    logic [SRB-1:0] a_bits_source = '0;
    logic           d_ready = 1'b0;
    logic           d_valid;
    logic [2:0]     d_bits_opcode;
    logic [1:0]     d_bits_param;
    logic [SZB-1:0] d_bits_size;
    logic [SRB-1:0] d_bits_source;
    logic           d_bits_sink;
    logic           d_bits_denied;
    logic [8*BB-1:0] d_bits_data;
    logic           d_bits_corrupt;
    logic           err_clear = 1'b0;
    logic [CB-1:0]  err_count;

    tl_error_slave #(
        .BEAT_BYTES(BB), .SOURCE_BITS(SRB), .SIZE_BITS(SZB),
        .QUEUE_DEPTH(QD), .COUNT_BITS(CB)
    ) dut (
        .clock(clock), .reset(reset),
        .a_ready(a_ready), .a_valid(a_valid),
        .a_bits_opcode(a_bits_opcode), .a_bits_size(a_bits_size),
        .a_bits_source(a_bits_source),
        .d_ready(d_ready), .d_valid(d_valid),
        .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
        .d_bits_size(d_bits_size), .d_bits_source(d_bits_source),
        .d_bits_sink(d_bits_sink), .d_bits_denied(d_bits_denied),
        .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt),
        .err_clear(err_clear), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        int sz;
        int src;
        int nb;
        bit cor;
    } rsp_t;

    rsp_t mq[$];
    int m_dbeat = 0;
    int m_aleft = 0;
    logic [2:0] m_hop;
    int m_hsz;
    int m_hsrc;
    int m_err = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_dhs = 0;
    int d_mode = 0;
    bit last_hs;
    bit prev_stall = 0;
    logic [12:0] prev_bits;

    function automatic int nbeats(int sz);
        return (sz <= 3) ? 1 : (1 << (sz - 3));
    endfunction

    function automatic rsp_t mk_rsp(logic [2:0] op, int sz, int src);
        rsp_t r;
        r.sz = sz;
        r.src = src;
        if (op == 3'd5) begin
            r.op = 3'd2; r.nb = 1; r.cor = 0;
        end else if (op >= 3'd2 && op <= 3'd4) begin
            r.op = 3'd1; r.nb = nbeats(sz); r.cor = 1;
        end else begin
            r.op = 3'd0; r.nb = 1; r.cor = 0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // One clock cycle: inputs are set at the negedge, checked 1 time unit
    // later, then the model advances as the posedge would.
    task automatic cyc();
        bit nonlast, exp_ar, a_hs, d_hs, pop;
        logic [12:0] cur;
        case (d_mode)
            0: d_ready = 1'b1;
            1: d_ready = 1'b0;
            2: d_ready = ~d_ready;
            default: d_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (m_aleft == 0)
            nonlast = a_bits_opcode < 3'd4 && nbeats(int'(a_bits_size)) > 1;
        else
            nonlast = m_aleft > 1;
        exp_ar = nonlast || mq.size() < QD;
        chk("a_ready", a_ready, exp_ar);
        chk("d_valid", d_valid, mq.size() != 0);
        chk("err_count", err_count, m_err);
        cur = {d_bits_opcode, d_bits_size, d_bits_source, d_bits_corrupt};
        if (prev_stall) chk("d_stable", cur, prev_bits);
        if (mq.size() != 0) begin
            chk("d_opcode", d_bits_opcode, mq[0].op);
            chk("d_size", d_bits_size, mq[0].sz);
            chk("d_source", d_bits_source, mq[0].src);
            chk("d_corrupt", d_bits_corrupt, mq[0].cor);
            chk("d_denied", d_bits_denied, 1);
            chk("d_param", d_bits_param, 0);
            chk("d_sink", d_bits_sink, 0);
            chk("d_data", d_bits_data, 0);
        end
        a_hs = a_valid && exp_ar;
        d_hs = d_ready && mq.size() != 0;
        prev_stall = (mq.size() != 0) && !d_ready;
        prev_bits = cur;
        pop = 0;
        if (d_hs) begin
            n_dhs++;
            m_dbeat++;
            if (m_dbeat == mq[0].nb) begin
                void'(mq.pop_front());
                m_dbeat = 0;
                pop = 1;
            end
        end
        if (a_hs) begin
            if (m_aleft == 0) begin
                if (nonlast) begin
                    m_aleft = nbeats(int'(a_bits_size)) - 1;
                    m_hop = a_bits_opcode;
                    m_hsz = int'(a_bits_size);
                    m_hsrc = int'(a_bits_source);
                end else begin
                    mq.push_back(mk_rsp(a_bits_opcode, int'(a_bits_size),
                                        int'(a_bits_source)));
                end
            end else begin
                m_aleft--;
                if (m_aleft == 0) mq.push_back(mk_rsp(m_hop, m_hsz, m_hsrc));
            end
        end
        if (err_clear) m_err = 0;
        else if (pop && m_err < CMAX) m_err++;
        last_hs = a_hs;
        @(negedge clock);
    endtask

    task automatic a_beat(input logic [2:0] op, input int sz, input int src);
        a_valid = 1'b1;
        a_bits_opcode = op;
        a_bits_size = SZB'(sz);
        a_bits_source = SRB'(src);
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (last_hs) begin
                a_valid = 1'b0;
                return;
            end
        end
        a_valid = 1'b0;
        timeout("a_handshake");
    endtask

    task automatic a_msg(input logic [2:0] op, input int sz, input int src);
        int n;
        n = (op < 3'd4) ? nbeats(sz) : 1;
        for (int i = 0; i < n; i++)
            a_beat(op, (i == 0) ? sz : int'($urandom_range(0, 15)), src);
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic drain();
        a_valid = 1'b0;
        d_mode = 0;
        for (int i = 0; i < 200 && mq.size() != 0; i++) cyc();
        if (mq.size() != 0) timeout("drain");
    endtask

    initial begin
        int base;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_err", err_count, 0);
        @(negedge clock);
        reset = 1'b0;
        idle(1);

        // Single Get, AccessAckData one cycle after the handshake
        d_mode = 0;
        a_msg(3'd4, 3, 7);
        #1;
        chk("get1_latency", d_valid, 1);
        chk("get1_corrupt", d_bits_corrupt, 1);
        #1;
        idle(2);
        chk("get1_err", err_count, 1);

        // 8-beat Get with d_ready toggling
        d_mode = 2;
        base = n_dhs;
        a_msg(3'd4, 6, 9);
        for (int i = 0; i < 60 && mq.size() != 0; i++) cyc();
        chk("burst_beats", n_dhs - base, 8);
        chk("burst_err", err_count, 2);

        // PutFull burst against a full queue
        d_mode = 1;
        a_msg(3'd4, 3, 1);
        a_msg(3'd4, 3, 2);
        a_beat(3'd0, 5, 3);
        a_beat(3'd0, 1, 3);
        a_beat(3'd0, 9, 3);
        a_valid = 1'b1;
        a_bits_size = 4'd5;
        repeat (3) cyc();
        #1;
        chk("put_last_blocked", a_ready, 0);
        #1;
        d_mode = 0;
        a_beat(3'd0, 5, 3);
        drain();

        // Mixed ordering: Hint, Logical, opcode 6
        a_msg(3'd5, 2, 1);
        a_msg(3'd3, 4, 2);
        a_msg(3'd6, 0, 3);
        drain();

        // Counter saturation, then clear racing a pop
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        for (int i = 0; i < 5; i++) a_msg(3'd4, 3, i);
        drain();
        chk("err_saturated", err_count, CMAX);
        d_mode = 1;
        a_msg(3'd4, 3, 4);
        idle(1);
        err_clear = 1'b1;
        d_mode = 0;
        cyc();
        err_clear = 1'b0;
        #1;
        chk("clear_wins", err_count, 0);
        #1;
        idle(1);

        // Reset during beat 2 of a 4-beat response
        d_mode = 0;
        a_msg(3'd4, 5, 5);
        cyc();
        reset = 1'b1;
        #1;
        chk("rst_mid_d_valid", d_valid, 0);
        chk("rst_mid_a_ready", a_ready, 0);
        mq.delete();
        m_dbeat = 0;
        m_aleft = 0;
        m_err = 0;
        prev_stall = 0;
        @(negedge clock);
        reset = 1'b0;
        idle(3);

        // Random traffic
        for (int k = 0; k < 200; k++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            d_mode = (sel == 1) ? 2 : (sel == 2 ? 3 : 0);
            err_clear = ($urandom_range(0, 19) == 0);
            a_msg(3'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 31)));
            err_clear = 1'b0;
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
        end
        drain();
        idle(2);
        chk("final_empty", d_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
